// File: rtl/hpu_axil_regs.sv
// AXI-Lite control/status register block for the HPU accelerator: loop bounds,
// item-memory count/write counter with auto-stop, sticky done flag. Optional irq via HPU_IRQ_EN.
`timescale 1ns/1ps
module hpu_axil_regs #(
  parameter int ADDR_W     = 20,
  parameter int RAND_W     = 16,
  parameter int DEF_ADDR_I = 299,
  parameter int DEF_ADDR_J = 2,
  parameter int DEF_RAND   = 1000,
  parameter int NUM_CORES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [31:0]       S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  input  logic              s_fin,
  output logic              run,
  output logic              matw,
  output logic              last,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic [RAND_W-1:0] random_num,
  output logic [RAND_W-1:0] mat_a
`ifdef HPU_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic [2:0] {INI, AW, W, AWW, AR1, AR2} state_t;

  localparam logic [9:0] REG_CTRL    = 10'd0;
  localparam logic [9:0] REG_STATUS  = 10'd1;
  localparam logic [9:0] REG_ADDR_I  = 10'd2;
  localparam logic [9:0] REG_ADDR_J  = 10'd3;
  localparam logic [9:0] REG_RAND    = 10'd4;
  localparam logic [9:0] REG_SCRATCH = 10'd5;
  localparam logic [9:0] REG_PARAM   = 10'd6;

  localparam logic [31:0] PARAM_WORD = {8'(NUM_CORES), 8'(ADDR_W), 8'(RAND_W), 8'h02};

  state_t      state;
  logic [9:0]  aw_word;
  logic [9:0]  ar_word;
  logic [31:0] wdata_held;
  logic [31:0] scratch;
  logic        done;
  logic        irq_en;

  logic        wr_fire;
  logic [9:0]  wr_word;
  logic [31:0] wr_data;
  logic [1:0]  wr_resp;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        unused_bits;

  assign unused_bits = ^{S_AXI_WSTRB, S_AXI_AWADDR[31:12], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:12], S_AXI_ARADDR[1:0]};

  // Address/data of the write that commits on this edge, whichever half arrived first.
  always_comb begin
    wr_fire = 1'b0;
    wr_word = aw_word;
    wr_data = wdata_held;
    case (state)
      INI: begin
        wr_fire = S_AXI_AWVALID & S_AXI_WVALID;
        wr_word = S_AXI_AWADDR[11:2];
        wr_data = S_AXI_WDATA;
      end
      AW: begin
        wr_fire = S_AXI_WVALID;
        wr_word = aw_word;
        wr_data = S_AXI_WDATA;
      end
      W: begin
        wr_fire = S_AXI_AWVALID;
        wr_word = S_AXI_AWADDR[11:2];
        wr_data = wdata_held;
      end
      default: begin
        wr_fire = 1'b0;
        wr_word = aw_word;
        wr_data = wdata_held;
      end
    endcase
    if (wr_word <= REG_PARAM) begin
      wr_resp = 2'b00;
    end else begin
      wr_resp = 2'b10;
    end
  end

  // Read mux; unmapped offsets return zero with SLVERR.
  always_comb begin
    rd_data = 32'd0;
    rd_resp = 2'b00;
    case (ar_word)
      REG_CTRL:    rd_data = {29'd0, last, run, matw};
      REG_STATUS:  rd_data = {irq_en, 29'd0, done, matw};
      REG_ADDR_I:  rd_data = 32'(addr_i);
      REG_ADDR_J:  rd_data = 32'(addr_j);
      REG_RAND:    rd_data = 32'(random_num);
      REG_SCRATCH: rd_data = scratch;
      REG_PARAM:   rd_data = PARAM_WORD;
      default: begin
        rd_data = 32'd0;
        rd_resp = 2'b10;
      end
    endcase
  end

  // Handshake FSM with registered ready/valid/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= INI;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b1;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= 2'b00;
      S_AXI_RDATA   <= 32'd0;
      aw_word       <= 10'd0;
      ar_word       <= 10'd0;
      wdata_held    <= 32'd0;
    end else begin
      case (state)
        INI: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            state         <= AWW;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= wr_resp;
          end else if (S_AXI_AWVALID) begin
            state         <= AW;
            aw_word       <= S_AXI_AWADDR[11:2];
            S_AXI_AWREADY <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
          end else if (S_AXI_WVALID) begin
            state         <= W;
            wdata_held    <= S_AXI_WDATA;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
          end else if (S_AXI_ARVALID) begin
            state         <= AR1;
            ar_word       <= S_AXI_ARADDR[11:2];
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
          end
        end
        AW: begin
          if (S_AXI_WVALID) begin
            state        <= AWW;
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_resp;
          end
        end
        W: begin
          if (S_AXI_AWVALID) begin
            state         <= AWW;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= wr_resp;
          end
        end
        AWW: begin
          if (S_AXI_BREADY) begin
            state         <= INI;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        AR1: begin
          state        <= AR2;
          S_AXI_RDATA  <= rd_data;
          S_AXI_RRESP  <= rd_resp;
          S_AXI_RVALID <= 1'b1;
        end
        AR2: begin
          if (S_AXI_RREADY) begin
            state         <= INI;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: begin
          state         <= INI;
          S_AXI_BVALID  <= 1'b0;
          S_AXI_RVALID  <= 1'b0;
          S_AXI_AWREADY <= 1'b1;
          S_AXI_WREADY  <= 1'b1;
          S_AXI_ARREADY <= 1'b1;
        end
      endcase
    end
  end

  // Control registers, item-memory counter with auto-stop and sticky done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      matw       <= 1'b0;
      last       <= 1'b0;
      addr_i     <= ADDR_W'(DEF_ADDR_I);
      addr_j     <= ADDR_W'(DEF_ADDR_J);
      random_num <= RAND_W'(DEF_RAND);
      mat_a      <= {RAND_W{1'b0}};
      scratch    <= 32'd0;
      done       <= 1'b0;
    end else begin
      // A CTRL write wins over the auto-stop in the same cycle.
      if (wr_fire && wr_word == REG_CTRL) begin
        {last, run, matw} <= wr_data[2:0];
      end else if (matw && mat_a == random_num) begin
        matw <= 1'b0;
      end
      if (matw) begin
        mat_a <= mat_a + RAND_W'(1);
      end else begin
        mat_a <= {RAND_W{1'b0}};
      end
      if (wr_fire && wr_word == REG_ADDR_I) addr_i <= wr_data[ADDR_W-1:0];
      if (wr_fire && wr_word == REG_ADDR_J) addr_j <= wr_data[ADDR_W-1:0];
      if (wr_fire && wr_word == REG_RAND) random_num <= wr_data[RAND_W-1:0];
      if (wr_fire && wr_word == REG_SCRATCH) scratch <= wr_data;
      done <= s_fin | (done & ~(wr_fire && wr_word == REG_STATUS && wr_data[1]));
    end
  end

`ifdef HPU_IRQ_EN
  // Interrupt enable and registered interrupt output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_fire && wr_word == REG_STATUS) irq_en <= wr_data[31];
      irq <= done & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_hpu_axil_regs.sv
// Scoreboard bench for hpu_axil_regs: directed AXI-Lite accesses, B/R responses checked by a monitor.
`timescale 1ns/1ps
module tb_hpu_axil_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        s_fin = 1'b0;
  logic        run, matw, last;
  logic [19:0] addr_i, addr_j;
  logic [15:0] random_num, mat_a;
`ifdef HPU_IRQ_EN
  logic        irq;
`endif

  hpu_axil_regs dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .s_fin(s_fin), .run(run), .matw(matw), .last(last),
    .addr_i(addr_i), .addr_j(addr_j), .random_num(random_num), .mat_a(mat_a)
`ifdef HPU_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] trace[$];
  bit          trace_on = 1'b0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every B or R handshake.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: got bresp %0d expected no response", bresp);
      end else begin
        mon_e = sb.pop_front();
        chk("b_kind", {31'd0, mon_e.is_rd}, 32'd0);
        chk("bresp", {30'd0, bresp}, {30'd0, mon_e.resp});
      end
    end
    if (rvalid && rready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL r_unexpected: got rdata 0x%08h expected no response", rdata);
      end else begin
        mon_e = sb.pop_front();
        chk("r_kind", {31'd0, mon_e.is_rd}, 32'd1);
        chk("rresp", {30'd0, rresp}, {30'd0, mon_e.resp});
        chk("rdata", rdata, mon_e.data);
      end
    end
    if (trace_on && matw) trace.push_back(mat_a);
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int aw_dly, input int w_dly,
                    input int b_dly, input logic [1:0] er, input bit fin);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs, got_b = 1'b0;
    int held = 0;
    sb.push_back('{is_rd: 1'b0, resp: er, data: 32'd0});
    bready = (b_dly == 0);
    for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
      awaddr  = a;
      wdata   = d;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if (fin && cyc == 0) s_fin = 1'b1;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      s_fin   = 1'b0;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("wr_accept", {31'd0, aw_done && w_done}, 32'd1);
    for (int cyc = 0; cyc < 40 && !got_b; cyc++) begin
      @(negedge clk);
      if (bvalid && bready) got_b = 1'b1;
      else if (bvalid) held++;
      @(posedge clk); #1;
      if (held >= b_dly) bready = 1'b1;
    end
    chk("wr_bresp_seen", {31'd0, got_b}, 32'd1);
    if (b_dly > 0) chk("bvalid_hold", held, b_dly);
    bready = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit hs = 1'b0, got_r = 1'b0;
    int lat = 1;
    sb.push_back('{is_rd: 1'b1, resp: er, data: ed});
    araddr  = a;
    arvalid = 1'b1;
    for (int cyc = 0; cyc < 40 && !hs; cyc++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    chk("rd_accept", {31'd0, hs}, 32'd1);
    for (int cyc = 0; cyc < 40 && !got_r; cyc++) begin
      @(negedge clk);
      if (rvalid) got_r = 1'b1;
      else lat++;
      @(posedge clk); #1;
    end
    chk("rd_seen", {31'd0, got_r}, 32'd1);
    chk("rd_latency", lat, 32'd2);
  endtask

  task automatic pulse_fin();
    s_fin = 1'b1;
    @(posedge clk); #1;
    s_fin = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_run", {31'd0, run}, 32'd0);
    chk("rst_matw", {31'd0, matw}, 32'd0);
    chk("rst_last", {31'd0, last}, 32'd0);
    chk("rst_addr_i", {12'd0, addr_i}, 32'd299);
    chk("rst_addr_j", {12'd0, addr_j}, 32'd2);
    chk("rst_random_num", {16'd0, random_num}, 32'd1000);
    chk("rst_mat_a", {16'd0, mat_a}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
`ifdef HPU_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    rd(32'h08, 32'd299, 2'b00);
    rd(32'h0C, 32'd2, 2'b00);
    rd(32'h10, 32'd1000, 2'b00);
    rd(32'h18, 32'h0114_1002, 2'b00);
    rd(32'h00, 32'd0, 2'b00);
    rd(32'h04, 32'd0, 2'b00);

    wr(32'h14, 32'hA5A5_5A5A, 0, 0, 0, 2'b00, 1'b0);
    rd(32'h14, 32'hA5A5_5A5A, 2'b00);
    wr(32'h18, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, 1'b0);
    rd(32'h18, 32'h0114_1002, 2'b00);

    // Item-memory fill of 6 entries with auto-stop.
    wr(32'h10, 32'd5, 0, 0, 0, 2'b00, 1'b0);
    trace.delete();
    trace_on = 1'b1;
    wr(32'h00, 32'd1, 0, 0, 0, 2'b00, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    trace_on = 1'b0;
    chk("matw_len", trace.size(), 32'd6);
    for (int i = 0; i < 6 && i < trace.size(); i++) chk("mat_a_seq", {16'd0, trace[i]}, i);
    chk("matw_stopped", {31'd0, matw}, 32'd0);
    rd(32'h04, 32'd0, 2'b00);
    rd(32'h00, 32'd0, 2'b00);

    // random_num = 0: matw lasts exactly one cycle.
    wr(32'h10, 32'd0, 0, 0, 0, 2'b00, 1'b0);
    trace.delete();
    trace_on = 1'b1;
    wr(32'h00, 32'd1, 0, 0, 0, 2'b00, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    trace_on = 1'b0;
    chk("matw0_len", trace.size(), 32'd1);
    if (trace.size() > 0) chk("matw0_mat_a", {16'd0, trace[0]}, 32'd0);

    wr(32'h00, 32'd6, 0, 0, 0, 2'b00, 1'b0);
    chk("ctrl_run", {31'd0, run}, 32'd1);
    chk("ctrl_last", {31'd0, last}, 32'd1);
    chk("ctrl_matw", {31'd0, matw}, 32'd0);
    rd(32'h00, 32'd6, 2'b00);
    wr(32'h00, 32'd0, 0, 0, 0, 2'b00, 1'b0);

    // Split address/data phases, truncation and BVALID hold.
    wr(32'h08, 32'h0001_2345, 0, 3, 0, 2'b00, 1'b0);
    chk("split_aw_first", {12'd0, addr_i}, 32'h0001_2345);
    wr(32'h0C, 32'hFFFF_FFFF, 2, 0, 3, 2'b00, 1'b0);
    chk("split_w_first", {12'd0, addr_j}, 32'h000F_FFFF);
    rd(32'h0C, 32'h000F_FFFF, 2'b00);
    wr(32'h10, 32'h0003_0007, 0, 0, 0, 2'b00, 1'b0);
    chk("rand_trunc", {16'd0, random_num}, 32'd7);

    // Unmapped offsets.
    wr(32'h1C, 32'hDEAD_BEEF, 0, 0, 0, 2'b10, 1'b0);
    rd(32'h40, 32'd0, 2'b10);
    rd(32'h14, 32'hA5A5_5A5A, 2'b00);
    chk("unmapped_addr_i", {12'd0, addr_i}, 32'h0001_2345);
    chk("unmapped_rand", {16'd0, random_num}, 32'd7);

    // Sticky done, W1C, and set winning over a coincident clear.
    pulse_fin();
    rd(32'h04, 32'd2, 2'b00);
    wr(32'h04, 32'd2, 0, 0, 0, 2'b00, 1'b0);
    rd(32'h04, 32'd0, 2'b00);
    pulse_fin();
    wr(32'h04, 32'd2, 0, 0, 0, 2'b00, 1'b1);
    rd(32'h04, 32'd2, 2'b00);
    wr(32'h04, 32'd2, 0, 0, 0, 2'b00, 1'b0);
    rd(32'h04, 32'd0, 2'b00);

`ifdef HPU_IRQ_EN
    wr(32'h04, 32'h8000_0000, 0, 0, 0, 2'b00, 1'b0);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    pulse_fin();
    @(posedge clk); #1;
    chk("irq_set", {31'd0, irq}, 32'd1);
    wr(32'h04, 32'h8000_0002, 0, 0, 0, 2'b00, 1'b0);
    chk("irq_clear", {31'd0, irq}, 32'd0);
    rd(32'h04, 32'h8000_0000, 2'b00);
`else
    wr(32'h04, 32'h8000_0000, 0, 0, 0, 2'b00, 1'b0);
    rd(32'h04, 32'd0, 2'b00);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
